// File: rtl/case_match_seq_pkg.sv
// Shared types and helpers for the runtime case-statement evaluator.
package case_match_pkg;

  // Widest operand any instance may use; table entries and extended values are held at this width.
  localparam int W_LIM  = 32;
  localparam int WW_LIM = 6;

  typedef enum logic [1:0] {IDLE, CTX, SCAN, DONE} state_e;

  typedef struct packed {
    logic [W_LIM-1:0]  val;
    logic [WW_LIM-1:0] width;
    logic              signed_f;
    logic              en;
  } item_t;

  function automatic int ww_of(input int w_max);
    return $clog2(w_max + 1);
  endfunction

  function automatic int iw_of(input int n_items);
    return (n_items <= 2) ? 1 : $clog2(n_items);
  endfunction

  // Mask val to width bits, then sign- or zero-extend to W_LIM bits.
  function automatic logic [W_LIM-1:0] extend(input logic [W_LIM-1:0]  val,
                                              input logic [WW_LIM-1:0] width,
                                              input logic              sgn);
    logic [W_LIM-1:0] mask;
    logic [W_LIM-1:0] res;
    logic [4:0]       top;
    mask = (width >= WW_LIM'(W_LIM)) ? '1 : ((W_LIM'(1) << width) - W_LIM'(1));
    top  = width[4:0] - 5'd1;
    res  = val & mask;
    if (sgn && (width != '0) && val[top]) res = res | ~mask;
    return res;
  endfunction

endpackage

// File: rtl/case_match_seq_if.sv
// Configuration, selector request and result handshake of case_match_seq.
interface case_match_seq_if
  import case_match_pkg::*;
#(
  parameter int W_MAX   = 8,
  parameter int N_ITEMS = 8
) ();
  localparam int WW = ww_of(W_MAX);
  localparam int IW = iw_of(N_ITEMS);

  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [W_MAX-1:0] cfg_val;
  logic [WW-1:0] cfg_width;
  logic          cfg_signed;
  logic          cfg_en;
  logic          s_valid;
  logic          s_ready;
  logic [W_MAX-1:0] s_sel;
  logic [WW-1:0] s_width;
  logic          s_signed;
  logic          m_valid;
  logic          m_ready;
  logic          m_hit;
  logic [IW-1:0] m_idx;
  logic          busy;

  modport master (
    output cfg_we, cfg_idx, cfg_val, cfg_width, cfg_signed, cfg_en,
    output s_valid, s_sel, s_width, s_signed, m_ready,
    input  s_ready, m_valid, m_hit, m_idx, busy
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_val, cfg_width, cfg_signed, cfg_en,
    input  s_valid, s_sel, s_width, s_signed, m_ready,
    output s_ready, m_valid, m_hit, m_idx, busy
  );
endinterface

// File: rtl/case_match_seq_cmp.sv
// Combinational match of one case item against the already-extended selector.
module case_item_cmp
  import case_match_pkg::*;
(
  input  item_t            item,
  input  logic [W_LIM-1:0] sel_ext,
  input  logic             ctx_signed,
  output logic             match
);
  logic [W_LIM-1:0] item_ext;

  // Both operands extend from at most W_MAX bits, so comparing the full extension equals the W_MAX-bit compare.
  always_comb begin
    item_ext = extend(item.val, item.width, ctx_signed);
    match    = item.en && (item.width != '0) && (item_ext == sel_ext);
  end
endmodule

// File: rtl/case_match_seq.sv
// Runtime case-statement evaluator: programmable item table, priority scan, first-hit result.
module case_match_seq
  import case_match_pkg::*;
#(
  parameter int W_MAX   = 8,
  parameter int N_ITEMS = 8
) (
  input logic             clk,
  input logic             rst,
  case_match_seq_if.slave bus
);
  localparam int WW = ww_of(W_MAX);
  localparam int IW = iw_of(N_ITEMS);

  state_e           state_q, state_d;
  item_t            tbl_q [N_ITEMS];
  logic [W_MAX-1:0] sel_q;
  logic [WW-1:0]    sw_q;
  logic             ss_q;
  logic             ctx_q;
  logic             ctx_d;
  logic [W_LIM-1:0] sel_ext_q;
  logic [W_LIM-1:0] sel_ext_d;
  logic [IW-1:0]    i_q;
  logic             hit_q;
  logic [IW-1:0]    idx_q;
  logic             cur_match;
  logic             last_item;

  // Context signedness: any live unsigned item makes the whole statement unsigned.
  always_comb begin
    ctx_d = ss_q;
    for (int k = 0; k < N_ITEMS; k++) begin
      if (tbl_q[k].en && (tbl_q[k].width != '0) && !tbl_q[k].signed_f) ctx_d = 1'b0;
    end
    sel_ext_d = extend(W_LIM'(sel_q), WW_LIM'(sw_q), ctx_d);
  end

  case_item_cmp u_cmp (
    .item       (tbl_q[i_q]),
    .sel_ext    (sel_ext_q),
    .ctx_signed (ctx_q),
    .match      (cur_match)
  );

  assign last_item = (i_q == IW'(N_ITEMS - 1));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.s_valid) state_d = CTX;
      CTX:     state_d = SCAN;
      SCAN:    if (cur_match || last_item) state_d = DONE;
      DONE:    if (bus.m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Table writes (idle only), request capture, context latch and scan progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_ITEMS; k++) tbl_q[k] <= '0;
      sel_q     <= '0;
      sw_q      <= '0;
      ss_q      <= 1'b0;
      ctx_q     <= 1'b0;
      sel_ext_q <= '0;
      i_q       <= '0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cfg_we && (int'(bus.cfg_idx) < N_ITEMS)) begin
            tbl_q[bus.cfg_idx] <= '{val:      W_LIM'(bus.cfg_val),
                                    width:    WW_LIM'(bus.cfg_width),
                                    signed_f: bus.cfg_signed,
                                    en:       bus.cfg_en};
          end
          if (bus.s_valid) begin
            sel_q <= bus.s_sel;
            sw_q  <= bus.s_width;
            ss_q  <= bus.s_signed;
            i_q   <= '0;
          end
        end
        CTX: begin
          ctx_q     <= ctx_d;
          sel_ext_q <= sel_ext_d;
        end
        SCAN: begin
          if (cur_match) begin
            hit_q <= 1'b1;
            idx_q <= i_q;
          end else if (last_item) begin
            hit_q <= 1'b0;
            idx_q <= '0;
          end else begin
            i_q <= i_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready = (state_q == IDLE);
  assign bus.m_valid = (state_q == DONE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.m_hit   = hit_q;
  assign bus.m_idx   = idx_q;
endmodule

// File: tb/tb_case_match_seq.sv
// Self-checking bench for case_match_seq with an integer-arithmetic reference model.
module tb_case_match_seq;
  localparam int W = 4;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  case_match_seq_if #(.W_MAX(W), .N_ITEMS(N)) bus ();
  case_match_seq #(.W_MAX(W), .N_ITEMS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int mv [N];
  int mw [N];
  bit ms [N];
  bit me [N];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Value of a w-bit operand as an integer under the statement's signedness.
  function automatic int sx(input int v, input int w, input bit sg);
    int m;
    m = v & ((1 << w) - 1);
    if (sg && w > 0 && m >= (1 << (w - 1))) m -= (1 << w);
    return m;
  endfunction

  task automatic model(input int sel, input int sw, input bit ss, output bit hit, output int idx);
    bit ctx;
    ctx = ss;
    for (int k = 0; k < N; k++) if (me[k] && mw[k] != 0 && !ms[k]) ctx = 0;
    hit = 0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      if (!hit && me[k] && mw[k] != 0 && sx(mv[k], mw[k], ctx) == sx(sel, sw, ctx)) begin
        hit = 1;
        idx = k;
      end
    end
  endtask

  task automatic cfg_wr(input int idx, input int val, input int w, input bit s, input bit en, input bit upd);
    bus.cfg_idx    = 2'(idx);
    bus.cfg_val    = 4'(val);
    bus.cfg_width  = 3'(w);
    bus.cfg_signed = s;
    bus.cfg_en     = en;
    bus.cfg_we     = 1'b1;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    if (upd) begin
      mv[idx] = val; mw[idx] = w; ms[idx] = s; me[idx] = en;
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) cfg_wr(k, 0, 0, 0, 0, 1);
  endtask

  task automatic issue_and_wait(input string tag, input int sel, input int sw, input bit ss);
    bit eh;
    int ei;
    int lat;
    model(sel, sw, ss, eh, ei);
    check_eq({tag, "_ready"}, bus.s_ready, 1);
    bus.s_sel    = 4'(sel);
    bus.s_width  = 3'(sw);
    bus.s_signed = ss;
    bus.s_valid  = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    lat = 0;
    while (!bus.m_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, eh ? ei + 2 : N + 1);
    check_eq({tag, "_hit"}, bus.m_hit, eh);
    check_eq({tag, "_idx"}, bus.m_idx, ei);
  endtask

  task automatic release_result();
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
  endtask

  task automatic request(input string tag, input int sel, input int sw, input bit ss);
    issue_and_wait(tag, sel, sw, ss);
    release_result();
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_val = 0; bus.cfg_width = 0;
    bus.cfg_signed = 0; bus.cfg_en = 0; bus.s_valid = 0; bus.s_sel = 0;
    bus.s_width = 0; bus.s_signed = 0; bus.m_ready = 0;
    for (int k = 0; k < N; k++) begin mv[k] = 0; mw[k] = 0; ms[k] = 0; me[k] = 0; end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", bus.m_valid, 0);
    check_eq("rst_ready", bus.s_ready, 1);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_hit", bus.m_hit, 0);
    check_eq("rst_idx", bus.m_idx, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Signed context, hit on item 1.
    cfg_wr(0, 1, 2, 1, 1, 1);
    cfg_wr(1, 1, 1, 1, 1, 1);
    request("sgn_hit", 3, 2, 1);

    // One unsigned item forces unsigned context: miss.
    cfg_wr(0, 0, 1, 0, 1, 1);
    request("uns_miss", 3, 2, 1);

    // Unsigned item elsewhere in the table, then made signed.
    clear_all();
    cfg_wr(0, 0, 1, 1, 1, 1);
    cfg_wr(1, 0, 3, 0, 1, 1);
    cfg_wr(2, 3, 2, 1, 1, 1);
    request("ctx_miss", 1, 1, 1);
    cfg_wr(1, 0, 3, 1, 1, 1);
    request("ctx_hit", 1, 1, 1);

    // Backpressure with a blocked table write.
    clear_all();
    cfg_wr(0, 1, 2, 1, 1, 1);
    cfg_wr(1, 1, 1, 1, 1, 1);
    issue_and_wait("bp", 3, 2, 1);
    cfg_wr(0, 3, 2, 1, 1, 0);
    for (int c = 0; c < 2; c++) begin
      check_eq("bp_hold_hit", bus.m_hit, 1);
      check_eq("bp_hold_idx", bus.m_idx, 1);
      check_eq("bp_hold_ready", bus.s_ready, 0);
      check_eq("bp_hold_valid", bus.m_valid, 1);
      @(posedge clk); #1;
    end
    check_eq("bp_hold_idx_end", bus.m_idx, 1);
    release_result();
    request("bp_rerun", 3, 2, 1);

    // Reset while scanning item 1.
    clear_all();
    cfg_wr(0, 5, 4, 1, 1, 1);
    cfg_wr(2, 3, 4, 1, 1, 1);
    bus.s_sel = 4'd3; bus.s_width = 3'd4; bus.s_signed = 1'b1; bus.s_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_busy", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_valid", bus.m_valid, 0);
    check_eq("mid_rst_ready", bus.s_ready, 1);
    check_eq("mid_rst_busy", bus.busy, 0);
    for (int k = 0; k < N; k++) me[k] = 0;
    request("after_rst", 3, 4, 1);

    // Label masked to its own width.
    clear_all();
    cfg_wr(0, 14, 1, 1, 1, 1);
    request("mask_hit", 0, 4, 1);
    request("mask_miss", 14, 4, 1);

    // Randomized table contents and selectors.
    for (int it = 0; it < 60; it++) begin
      int nwr;
      nwr = $urandom_range(0, 2);
      for (int k = 0; k < nwr; k++) begin
        cfg_wr($urandom_range(0, N - 1), $urandom_range(0, 15), $urandom_range(0, W),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1);
      end
      request("rnd", $urandom_range(0, 15), $urandom_range(1, W), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
